usb_tx_arbiter: RTL and testbench

- Round-robin arbiter between NUM_PERIPH peripheral TX FIFOs and the FT601 controller's write path.
- Selects one non-empty peripheral FIFO and bursts up to MAX_BURST words from it, then rotates to the next.
- Presents one registered word with a valid flag (periph_data_available) and accepts a pop strobe (read_periph_data) from the controller.
- Also aggregates per-FIFO init status into periph_ready.

---
 rtl/usb_pkg.sv | 16 +
 rtl/rr_select.sv | 32 +++
 rtl/usb_tx_arbiter.sv | 117 +++++++++++
 tb/tb_usb_tx_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// Shared USB/FT601 definitions: arbiter state encoding, bus width, index helper.
package usb_pkg;

    localparam int DATA_W = 32;

    typedef enum logic {
        IDLE,
        BURST
    } arb_state_t;

    // Round-robin successor; handles non-power-of-two counts.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_select
    import usb_pkg::*;
#(
    parameter int N    = 8,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic            found,
    output logic [ID_W-1:0] idx
);

    int j;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!found && req[j[ID_W-1:0]]) begin
                found = 1'b1;
                idx   = ID_W'(j);
            end
        end
    end

endmodule

// File: rtl/usb_tx_arbiter.sv
// Round-robin burst arbiter from peripheral FWFT TX FIFOs into a single
// registered output slot feeding the FT601 write path.
module usb_tx_arbiter
    import usb_pkg::*;
#(
    parameter int NUM_PERIPH = 8,
    parameter int DATA_W     = usb_pkg::DATA_W,
    parameter int MAX_BURST  = 16,
    localparam int ID_W      = $clog2(NUM_PERIPH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_PERIPH-1:0]        fifo_init_done,
    input  logic [NUM_PERIPH-1:0]        fifo_empty,
    input  logic [NUM_PERIPH*DATA_W-1:0] fifo_data,
    output logic [NUM_PERIPH-1:0]        fifo_rd_en,
    output logic [DATA_W-1:0]            tx_data,
    output logic                         periph_data_available,
    input  logic                         read_periph_data,
    output logic                         periph_ready,
    output logic [ID_W-1:0]              grant_id
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_t      state, state_next;
    logic [ID_W-1:0] rr_ptr, rr_ptr_next, grant_next, sel_idx;
    logic [CNT_W-1:0] burst_cnt, burst_cnt_next;
    logic            slot_pop, slot_free, sel_found, do_load;

    // The slot can refill in the same cycle it is drained, sustaining 1 word/cycle.
    assign slot_pop  = read_periph_data && periph_data_available;
    assign slot_free = !periph_data_available || slot_pop;

    rr_select #(
        .N   (NUM_PERIPH),
        .ID_W(ID_W)
    ) u_rr_select (
        .req  (~fifo_empty),
        .ptr  (rr_ptr),
        .found(sel_found),
        .idx  (sel_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant_id  <= '0;
            burst_cnt <= '0;
        end else begin
            state     <= state_next;
            rr_ptr    <= rr_ptr_next;
            grant_id  <= grant_next;
            burst_cnt <= burst_cnt_next;
        end
    end

    always_comb begin
        state_next     = state;
        rr_ptr_next    = rr_ptr;
        grant_next     = grant_id;
        burst_cnt_next = burst_cnt;
        if (!periph_ready) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        grant_next     = sel_idx;
                        burst_cnt_next = '0;
                        state_next     = BURST;
                    end
                end
                BURST: begin
                    if (slot_free) begin
                        if (fifo_empty[grant_id]) begin
                            state_next  = IDLE;
                            rr_ptr_next = ID_W'(wrap_inc(int'(grant_id), NUM_PERIPH));
                        end else begin
                            burst_cnt_next = burst_cnt + 1'b1;
                            if (burst_cnt == CNT_W'(MAX_BURST - 1)) begin
                                state_next  = IDLE;
                                rr_ptr_next = ID_W'(wrap_inc(int'(grant_id), NUM_PERIPH));
                            end
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        do_load              = periph_ready && (state == BURST) && slot_free && !fifo_empty[grant_id];
        fifo_rd_en           = '0;
        fifo_rd_en[grant_id] = do_load;
    end

    // Output slot and init-status aggregation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_data               <= '0;
            periph_data_available <= 1'b0;
            periph_ready          <= 1'b0;
        end else begin
            periph_ready <= &fifo_init_done;
            if (do_load) begin
                tx_data               <= fifo_data[int'(grant_id)*DATA_W +: DATA_W];
                periph_data_available <= 1'b1;
            end else if (slot_pop) begin
                periph_data_available <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_usb_tx_arbiter.sv
// Directed bench for usb_tx_arbiter: FWFT FIFO models, word scoreboard, 8- and 5-port instances.
module tb_usb_tx_arbiter;
    import usb_pkg::*;

    localparam int NA  = 8;
    localparam int NB  = 5;
    localparam int MBA = 16;
    localparam int MBB = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NA-1:0]    init_a, empty_a, rd_a, pend_a;
    logic [NA*32-1:0] data_a;
    logic [31:0]      tx_a;
    logic             avail_a, read_a, ready_a;
    logic [2:0]       grant_a;

    logic [NB-1:0]    init_b, empty_b, rd_b, pend_b;
    logic [NB*32-1:0] data_b;
    logic [31:0]      tx_b;
    logic             avail_b, read_b, ready_b;
    logic [2:0]       grant_b;

    logic [31:0] fq [13][$];
    logic [31:0] exp_a[$];
    logic [31:0] exp_b[$];
    int vectors = 0;
    int miscompares = 0;
    int pops_a = 0;
    int pops_b = 0;

    usb_tx_arbiter #(.NUM_PERIPH(NA), .DATA_W(32), .MAX_BURST(MBA)) dut_a (
        .clk(clk), .rst(rst), .fifo_init_done(init_a), .fifo_empty(empty_a),
        .fifo_data(data_a), .fifo_rd_en(rd_a), .tx_data(tx_a),
        .periph_data_available(avail_a), .read_periph_data(read_a),
        .periph_ready(ready_a), .grant_id(grant_a)
    );

    usb_tx_arbiter #(.NUM_PERIPH(NB), .DATA_W(32), .MAX_BURST(MBB)) dut_b (
        .clk(clk), .rst(rst), .fifo_init_done(init_b), .fifo_empty(empty_b),
        .fifo_data(data_b), .fifo_rd_en(rd_b), .tx_data(tx_b),
        .periph_data_available(avail_b), .read_periph_data(read_b),
        .periph_ready(ready_b), .grant_id(grant_b)
    );

    function automatic logic [31:0] mkWord(input int f, input int s);
        return {8'(f), 24'(s)};
    endfunction

    function automatic int fifoTotal();
        int t = 0;
        for (int i = 0; i < 13; i++) t += fq[i].size();
        return t;
    endfunction

    // Expected per-cycle pop vector while FIFOs 0 and 5 alternate 16-word bursts.
    function automatic logic [7:0] burstPattern(input int c);
        int j;
        if (c == 0) return 8'h00;
        j = c - 1;
        if (j % 17 == 16) return 8'h00;
        return ((j / 17) % 2 == 0) ? 8'h01 : 8'h20;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic refreshFifos();
        for (int i = 0; i < NA; i++) begin
            empty_a[i]          = (fq[i].size() == 0);
            data_a[i*32 +: 32]  = (fq[i].size() == 0) ? 32'h0 : fq[i][0];
        end
        for (int i = 0; i < NB; i++) begin
            empty_b[i]          = (fq[8+i].size() == 0);
            data_b[i*32 +: 32]  = (fq[8+i].size() == 0) ? 32'h0 : fq[8+i][0];
        end
    endtask

    task automatic applyStimulus(input int f, input int first, input int count);
        for (int k = 0; k < count; k++) fq[f].push_back(mkWord(f, first + k));
        refreshFifos();
    endtask

    task automatic expectWords(input bit on_b, input int f, input int first, input int count);
        for (int k = 0; k < count; k++) begin
            if (on_b) exp_b.push_back(mkWord(f, first + k));
            else      exp_a.push_back(mkWord(f, first + k));
        end
    endtask

    // One clock: monitor at the falling edge, FIFO pops just after the rising edge.
    task automatic tick();
        @(negedge clk);
        if (!rst) begin
            if (read_a && avail_a) begin
                if (exp_a.size() == 0) checkOutput("scoreA_extra", 32'd1, 32'd0);
                else checkOutput("scoreA_word", tx_a, exp_a.pop_front());
            end
            if (read_b && avail_b) begin
                if (exp_b.size() == 0) checkOutput("scoreB_extra", 32'd1, 32'd0);
                else checkOutput("scoreB_word", tx_b, exp_b.pop_front());
            end
            if (rd_a != '0) begin
                checkOutput("rdA_onehot", 32'($onehot(rd_a)), 32'd1);
                checkOutput("rdA_nonempty", 32'(|(rd_a & empty_a)), 32'd0);
                pops_a++;
            end
            if (rd_b != '0) begin
                checkOutput("rdB_onehot", 32'($onehot(rd_b)), 32'd1);
                checkOutput("rdB_nonempty", 32'(|(rd_b & empty_b)), 32'd0);
                pops_b++;
            end
            checkOutput("grantB_range", 32'(grant_b < 3'(NB)), 32'd1);
        end
        pend_a = rd_a;
        pend_b = rd_b;
        @(posedge clk);
        #1;
        for (int i = 0; i < NA; i++) if (pend_a[i] && fq[i].size() > 0) void'(fq[i].pop_front());
        for (int i = 0; i < NB; i++) if (pend_b[i] && fq[8+i].size() > 0) void'(fq[8+i].pop_front());
        refreshFifos();
    endtask

    task automatic drainAll(input string tag, input int budget);
        int n = 0;
        while ((exp_a.size() != 0 || exp_b.size() != 0 || fifoTotal() != 0 || avail_a || avail_b) && n < budget) begin
            tick();
            n++;
        end
        checkOutput({tag, "_drained"}, 32'(n < budget), 32'd1);
        repeat (3) tick();
    endtask

    task automatic resetDut();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        int p0, p1, n;
        rst    = 1'b1;
        init_a = '1;
        init_b = '1;
        read_a = 1'b0;
        read_b = 1'b1;
        pend_a = '0;
        pend_b = '0;
        refreshFifos();

        // Reset values and one-cycle periph_ready latency.
        tick();
        checkOutput("rst_tx", tx_a, 32'h0);
        checkOutput("rst_avail", 32'(avail_a), 32'd0);
        checkOutput("rst_rd", 32'(rd_a), 32'd0);
        checkOutput("rst_grant", 32'(grant_a), 32'd0);
        checkOutput("rst_ready", 32'(ready_a), 32'd0);
        checkOutput("rst_readyB", 32'(ready_b), 32'd0);
        rst = 1'b0;
        checkOutput("ready_before_edge", 32'(ready_a), 32'd0);
        tick();
        checkOutput("ready_after_edge", 32'(ready_a), 32'd1);
        for (int c = 0; c < 5; c++) begin
            tick();
            checkOutput("idle_avail", 32'(avail_a), 32'd0);
            checkOutput("idle_rd", 32'(pend_a), 32'd0);
        end

        // Single FIFO 3 with five words, consumer always ready.
        read_a = 1'b1;
        applyStimulus(3, 0, 5);
        expectWords(0, 3, 0, 5);
        tick();
        checkOutput("f3_grant", 32'(grant_a), 32'd3);
        for (int c = 0; c < 5; c++) begin
            tick();
            checkOutput("f3_rd", 32'(pend_a), 32'h08);
        end
        tick();
        checkOutput("f3_rd_end", 32'(pend_a), 32'h00);
        drainAll("f3", 50);

        // Pointer now sits at 4: FIFO 5 must win over FIFO 2.
        applyStimulus(2, 0, 2);
        applyStimulus(5, 0, 2);
        expectWords(0, 5, 0, 2);
        expectWords(0, 2, 0, 2);
        tick();
        checkOutput("rrptr4_grant", 32'(grant_a), 32'd5);
        drainAll("rrptr4", 50);

        // Two 40-word FIFOs alternate in MAX_BURST chunks with one idle cycle per switch.
        resetDut();
        applyStimulus(0, 0, 40);
        applyStimulus(5, 0, 40);
        for (int b = 0; b < 2; b++) begin
            expectWords(0, 0, b * 16, 16);
            expectWords(0, 5, b * 16, 16);
        end
        expectWords(0, 0, 32, 8);
        expectWords(0, 5, 32, 8);
        for (int c = 0; c < 69; c++) begin
            tick();
            checkOutput("burst_seq", 32'(pend_a), 32'(burstPattern(c)));
        end
        drainAll("burst", 200);

        // Back-pressure: a full, unread slot blocks further pops.
        resetDut();
        read_a = 1'b0;
        p0 = pops_a;
        applyStimulus(1, 0, 4);
        expectWords(0, 1, 0, 4);
        repeat (12) tick();
        checkOutput("bp_pops", 32'(pops_a - p0), 32'd1);
        checkOutput("bp_avail", 32'(avail_a), 32'd1);
        checkOutput("bp_hold", tx_a, mkWord(1, 0));
        read_a = 1'b1;
        drainAll("bp", 50);
        checkOutput("bp_total", 32'(pops_a - p0), 32'd4);

        // Init status drops mid-burst on FIFO 6.
        resetDut();
        read_a = 1'b1;
        p0 = pops_a;
        applyStimulus(6, 0, 10);
        expectWords(0, 6, 0, 10);
        n = 0;
        while (pops_a - p0 < 3 && n < 20) begin
            tick();
            n++;
        end
        checkOutput("init_start", 32'(n < 20), 32'd1);
        init_a[2] = 1'b0;
        read_a    = 1'b0;
        tick();
        p1 = pops_a;
        repeat (8) tick();
        checkOutput("init_no_pop", 32'(pops_a - p1), 32'd0);
        checkOutput("init_ready", 32'(ready_a), 32'd0);
        checkOutput("init_slot_kept", 32'(avail_a), 32'd1);
        read_a = 1'b1;
        tick();
        read_a = 1'b0;
        checkOutput("init_pop_clears", 32'(avail_a), 32'd0);
        checkOutput("init_no_pop2", 32'(pops_a - p1), 32'd0);
        init_a[2] = 1'b1;
        read_a    = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (pend_a == '0 && n < 10);
        checkOutput("init_resume_rd", 32'(pend_a), 32'h40);
        checkOutput("init_resume_grant", 32'(grant_a), 32'd6);
        drainAll("init", 50);

        // Five-port instance: park pointer at 4, then wrap from 4 to 0.
        applyStimulus(8 + 3, 0, 2);
        expectWords(1, 8 + 3, 0, 2);
        drainAll("b5_prep", 50);
        applyStimulus(8 + 4, 0, 6);
        applyStimulus(8 + 0, 0, 6);
        expectWords(1, 8 + 4, 0, 4);
        expectWords(1, 8 + 0, 0, 4);
        expectWords(1, 8 + 4, 4, 2);
        expectWords(1, 8 + 0, 4, 2);
        n = 0;
        do begin
            tick();
            n++;
        end while (pend_b == '0 && n < 10);
        checkOutput("b5_first_rd", 32'(pend_b), 32'h10);
        checkOutput("b5_first_grant", 32'(grant_b), 32'd4);
        drainAll("b5", 100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
